// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed scan controller for an N-digit common-anode display
// Double-buffered load port; new values are applied only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              numout,
  output logic [NUM_DIGITS-1:0]   anode_n,
  output logic                    blank,
  output logic                    frame_tick
);

  localparam int MAXC = (BLANK_CYC > REFRESH_DIV) ? BLANK_CYC : REFRESH_DIV;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int DW   = 4 * NUM_DIGITS;

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                state, state_nx;
  logic [IW-1:0]         idx, idx_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [DW-1:0]         active, active_nx;
  logic [DW-1:0]         shadow;
  logic                  pending, pending_nx;
  logic                  wrap;
  logic                  transfer;
  logic [NUM_DIGITS-1:0] onehot_nx;

  assign transfer  = load_valid & ~pending;
  assign onehot_nx = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_nx;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    cnt_nx   = cnt + CW'(1);
    wrap     = 1'b0;
    case (state)
      S_BLANK: begin
        if (cnt == CW'(BLANK_CYC - 1)) begin
          cnt_nx   = '0;
          state_nx = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt == CW'(REFRESH_DIV - 1)) begin
          cnt_nx   = '0;
          state_nx = S_BLANK;
          if (idx == IW'(NUM_DIGITS - 1)) begin
            idx_nx = '0;
            wrap   = 1'b1;
          end else begin
            idx_nx = idx + IW'(1);
          end
        end
      end
      default: state_nx = S_BLANK;
    endcase
  end

  // A transfer coinciding with a wrap only fills the shadow; it is applied at the next wrap.
  always_comb begin
    active_nx  = active;
    pending_nx = pending;
    if (wrap && pending) begin
      active_nx  = shadow;
      pending_nx = 1'b0;
    end else if (transfer) begin
      pending_nx = 1'b1;
    end
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_BLANK;
      idx        <= '0;
      cnt        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      anode_n    <= '1;
      numout     <= '0;
      blank      <= 1'b1;
      load_ready <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      active     <= active_nx;
      pending    <= pending_nx;
      if (transfer) shadow <= load_data;
      anode_n    <= (state_nx == S_DRIVE) ? ~(onehot_nx & digit_en) : '1;
      numout     <= active_nx[{idx_nx, 2'b00} +: 4];
      blank      <= (state_nx == S_BLANK) | ~digit_en[idx_nx];
      load_ready <= ~pending_nx;
      frame_tick <= wrap;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - self-checking bench for seven_seg_scan_ctrl
// Frame-position reference model feeds an expected-output queue compared each cycle.
module tb_seven_seg_scan_ctrl;

  localparam int ND    = 4;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = BC + RD;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  numout;
  logic [3:0]  anode_n;
  logic        blank;
  logic        frame_tick;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .BLANK_CYC  (BC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .digit_en  (digit_en),
    .numout    (numout),
    .anode_n   (anode_n),
    .blank     (blank),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          m_p;
  logic [15:0] m_active;
  logic [15:0] m_shadow;
  logic        m_pending;
  logic [10:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h (anode_n,numout,blank,load_ready,frame_tick)", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] model_out(input int p, input logic tick);
    int          d;
    bit          drv;
    logic [15:0] sh;
    logic [3:0]  an;
    logic        bl;
    d   = p / SLOT;
    drv = (p % SLOT) >= BC;
    sh  = m_active >> (4 * d);
    an  = drv ? ~(digit_en & (4'b0001 << d)) : 4'hF;
    bl  = !drv || !digit_en[d];
    return {an, sh[3:0], bl, !m_pending, tick};
  endfunction

  task automatic compare_now(input string tag);
    logic [10:0] e;
    e = exp_q.pop_front();
    check_eq(tag, {21'b0, anode_n, numout, blank, load_ready, frame_tick}, {21'b0, e});
  endtask

  // Called at a falling edge with inputs already set; advances one clock.
  task automatic cycle();
    logic xfer;
    logic wrap;
    xfer = load_valid && !m_pending;
    wrap = (m_p == FRAME - 1);
    if (wrap && m_pending) begin
      m_active  = m_shadow;
      m_pending = 1'b0;
    end
    if (xfer) begin
      m_shadow  = load_data;
      m_pending = 1'b1;
    end
    m_p = wrap ? 0 : m_p + 1;
    exp_q.push_back(model_out(m_p, wrap));
    @(posedge clk);
    @(negedge clk);
    compare_now($sformatf("p%0d", m_p));
    if (xfer) load_valid = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 2 * FRAME && m_p != target; i++) cycle();
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    load_valid = 1'b0;
    #1;
    m_p       = 0;
    m_active  = '0;
    m_shadow  = '0;
    m_pending = 1'b0;
    exp_q.push_back(model_out(0, 1'b0));
    compare_now("rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_q.push_back(model_out(0, 1'b0));
    compare_now("rel");
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    run(FRAME + 2);

    run_to(9);
    load_data  = 16'h1234;
    load_valid = 1'b1;
    cycle();
    load_data  = 16'hABCD;
    load_valid = 1'b1;
    run(2 * FRAME + 5);

    digit_en = 4'b1011;
    run(FRAME);
    digit_en = 4'hF;
    run(2);
    for (int i = 0; i < 2 * FRAME; i++) begin
      digit_en = 4'($urandom);
      cycle();
    end
    digit_en = 4'hF;

    run_to(1);
    load_data  = 16'h9E07;
    load_valid = 1'b1;
    cycle();
    run_to(15);
    do_reset();
    run(FRAME + 6);

    run_to(FRAME - 1);
    load_data  = 16'h5678;
    load_valid = 1'b1;
    cycle();
    run(2 * FRAME + 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
